// File: rtl/decode_stage_pipelined_if.sv
// Fetch/writeback-to-decode and decode-to-execute signal bundle for decode_stage_pipelined.
// master drives instructions, handshakes and the write port; slave is the decode stage.
interface decode_stage_pipelined_if #(
  parameter int N = 32
);
  logic          in_valid;
  logic [31:0]   inst;
  logic [N-1:0]  pc;
  logic          in_ready;
  logic          ex_ready;
  logic          flush;
  logic          we3;
  logic [3:0]    a3;
  logic [N-1:0]  wd3;
  logic          out_valid;
  logic [2:0]    out_cond;
  logic [1:0]    out_op;
  logic          out_imm_sig;
  logic [4:0]    out_cmd;
  logic [3:0]    out_rd;
  logic [3:0]    out_a1;
  logic [3:0]    out_a2;
  logic [N-1:0]  out_rd1;
  logic [N-1:0]  out_rd2;
  logic [N-1:0]  out_ext;
  logic [N-1:0]  out_pc;
  logic          hazard_stall;
  logic [N-1:0]  dbg_r0;
  logic [N-1:0]  dbg_r1;

  modport master (
    output in_valid, inst, pc, ex_ready, flush, we3, a3, wd3,
    input  in_ready, out_valid, out_cond, out_op, out_imm_sig, out_cmd, out_rd,
           out_a1, out_a2, out_rd1, out_rd2, out_ext, out_pc, hazard_stall,
           dbg_r0, dbg_r1
  );

  modport slave (
    input  in_valid, inst, pc, ex_ready, flush, we3, a3, wd3,
    output in_ready, out_valid, out_cond, out_op, out_imm_sig, out_cmd, out_rd,
           out_a1, out_a2, out_rd1, out_rd2, out_ext, out_pc, hazard_stall,
           dbg_r0, dbg_r1
  );
endinterface

// File: rtl/decode_stage_pipelined.sv
// Registered decode stage: field split, register-file read with write bypass,
// immediate extension, decode->execute register with handshake, flush and load-use stall.
module decode_stage_pipelined #(
  parameter int N      = 32,
  parameter int NREGS  = 16,
  parameter int PC_REG = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  decode_stage_pipelined_if.slave bus
);
  localparam int         AW        = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [3:0] PC_IDX    = 4'(PC_REG);
  localparam logic [4:0] NREGS_LIM = 5'(NREGS);

  logic [N-1:0] regs [NREGS];

  logic [1:0]   op;
  logic [4:0]   cmd;
  logic [3:0]   rd, rn, rs;
  logic         is_store;
  logic [3:0]   a1, a2;
  logic [N-1:0] rd1, rd2, ext;
  logic [65:0]  branch_wide;
  logic         wr_en;
  logic         hazard;

  logic         held_valid;
  logic [2:0]   held_cond;
  logic [1:0]   held_op;
  logic         held_imm_sig;
  logic [4:0]   held_cmd;
  logic [3:0]   held_rd, held_a1, held_a2;
  logic [N-1:0] held_rd1, held_rd2, held_ext, held_pc;

  assign op       = bus.inst[28:27];
  assign cmd      = bus.inst[25:21];
  assign rd       = bus.inst[20:17];
  assign rn       = bus.inst[16:13];
  assign rs       = bus.inst[3:0];
  assign is_store = (op == 2'b01) && !cmd[0];
  assign a1       = (op == 2'b10) ? PC_IDX : rn;
  assign a2       = is_store ? rd : rs;

  // PC alias wins over range check, which wins over the write bypass
  always_comb begin
    rd1 = '0;
    if (a1 == PC_IDX)                     rd1 = bus.pc;
    else if ({1'b0, a1} >= NREGS_LIM)     rd1 = '0;
    else if (bus.we3 && (bus.a3 == a1))   rd1 = bus.wd3;
    else                                  rd1 = regs[a1[AW-1:0]];
  end

  always_comb begin
    rd2 = '0;
    if (a2 == PC_IDX)                     rd2 = bus.pc;
    else if ({1'b0, a2} >= NREGS_LIM)     rd2 = '0;
    else if (bus.we3 && (bus.a3 == a2))   rd2 = bus.wd3;
    else                                  rd2 = regs[a2[AW-1:0]];
  end

  // Branch offset is sign-extended and word-scaled at 66 bits, then cut to N
  assign branch_wide = {{37{bus.inst[26]}}, bus.inst[26:0], 2'b00};

  always_comb begin
    ext = '0;
    case (op)
      2'b00:   ext = {{(N-13){1'b0}}, bus.inst[12:0]};
      2'b01:   ext = {{(N-13){bus.inst[12]}}, bus.inst[12:0]};
      default: ext = branch_wide[N-1:0];
    endcase
  end

  assign hazard = bus.in_valid && held_valid && (held_op == 2'b01) && held_cmd[0] &&
                  (held_rd != PC_IDX) && ((held_rd == a1) || (held_rd == a2));

  assign wr_en = bus.we3 && ({1'b0, bus.a3} < NREGS_LIM) && (bus.a3 != PC_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.a3[AW-1:0]] <= bus.wd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_valid   <= 1'b0;
      held_cond    <= '0;
      held_op      <= '0;
      held_imm_sig <= 1'b0;
      held_cmd     <= '0;
      held_rd      <= '0;
      held_a1      <= '0;
      held_a2      <= '0;
      held_rd1     <= '0;
      held_rd2     <= '0;
      held_ext     <= '0;
      held_pc      <= '0;
    end else if (bus.flush) begin
      held_valid <= 1'b0;
    end else if (!bus.ex_ready) begin
      held_valid <= held_valid;
    end else if (hazard) begin
      held_valid <= 1'b0;
    end else begin
      // fields load even for an invalid input so the register tracks fetch
      held_valid   <= bus.in_valid;
      held_cond    <= bus.inst[31:29];
      held_op      <= op;
      held_imm_sig <= bus.inst[26];
      held_cmd     <= cmd;
      held_rd      <= rd;
      held_a1      <= a1;
      held_a2      <= a2;
      held_rd1     <= rd1;
      held_rd2     <= rd2;
      held_ext     <= ext;
      held_pc      <= bus.pc;
    end
  end

  assign bus.in_ready     = bus.ex_ready && !hazard;
  assign bus.hazard_stall = hazard;
  assign bus.out_valid    = held_valid;
  assign bus.out_cond     = held_cond;
  assign bus.out_op       = held_op;
  assign bus.out_imm_sig  = held_imm_sig;
  assign bus.out_cmd      = held_cmd;
  assign bus.out_rd       = held_rd;
  assign bus.out_a1       = held_a1;
  assign bus.out_a2       = held_a2;
  assign bus.out_rd1      = held_rd1;
  assign bus.out_rd2      = held_rd2;
  assign bus.out_ext      = held_ext;
  assign bus.out_pc       = held_pc;
  assign bus.dbg_r0       = regs[0];
  assign bus.dbg_r1       = regs[1];
endmodule
